// File: rtl/sha1_pad.sv
// sha1_pad: byte-stream message padder feeding the SHA-1 engine.
// Collects bytes into a 512-bit block register, appends the 0x80 marker,
// zero fill and the 64-bit big-endian bit length, and presents whole
// blocks on a valid/ready handshake with a final-block flag.
module sha1_pad (
  input  logic         wb_clk_i,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [511:0] block_o,
  output logic         block_last
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [511:0]   r_block;
  logic [511:0]   w_block_next;
  logic [6:0]     r_byte_idx;
  logic [6:0]     w_byte_idx_next;
  logic [63:0]    r_bit_len;
  logic [63:0]    w_bit_len_next;
  logic           r_marker_done;
  logic           w_marker_done_next;
  logic           r_last_seen;
  logic           w_last_seen_next;
  logic           r_block_last;
  logic           w_block_last_next;

  logic           w_xfer;
  logic           w_hs;
  logic           w_len_here;

  // Input is only taken while filling; reset holds the stream off.
  assign in_ready    = (r_state == S_FILL) && !reset;
  assign w_xfer      = in_valid && in_ready;
  assign w_hs        = (r_state == S_EMIT) && block_ready;
  // Length fits in this block if the marker lands at byte 55 or earlier,
  // or the marker already went out in the previous block.
  assign w_len_here  = r_marker_done || (r_byte_idx <= 7'd55);

  assign block_valid = (r_state == S_EMIT);
  assign block_o     = r_block;
  assign block_last  = r_block_last;

  // Per-byte next value of the block register. Byte n lives in word n/4,
  // earliest byte of each word in its most significant lane.
  for (genvar gi = 0; gi < 64; gi++) begin : g_byte
    localparam int LSB = 32 * (gi / 4) + 24 - 8 * (gi % 4);
    logic [7:0] w_nb;
    logic [7:0] w_len_byte;
    logic       w_len_en;

    if (gi >= 56) begin : g_len
      assign w_len_byte = r_bit_len[63 - 8 * (gi - 56) -: 8];
      assign w_len_en   = w_len_here;
    end else begin : g_nolen
      assign w_len_byte = 8'h00;
      assign w_len_en   = 1'b0;
    end

    // Select the new content of this byte lane for the current state.
    always_comb begin
      w_nb = r_block[LSB +: 8];
      case (r_state)
        S_FILL: begin
          if (w_xfer && (r_byte_idx == 7'(gi))) begin
            w_nb = in_data;
          end
        end
        S_PAD: begin
          if (!r_marker_done && (r_byte_idx == 7'(gi))) begin
            w_nb = 8'h80;
          end else if ((7'(gi) > r_byte_idx) ||
                       (r_marker_done && (7'(gi) >= r_byte_idx))) begin
            w_nb = 8'h00;
          end
          if (w_len_en) begin
            w_nb = w_len_byte;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            w_nb = 8'h00;
          end
        end
        default: begin
          w_nb = r_block[LSB +: 8];
        end
      endcase
    end

    assign w_block_next[LSB +: 8] = w_nb;
  end

  // Next-state logic for the FILL / PAD / EMIT sequencer and its counters.
  always_comb begin
    w_state_next       = r_state;
    w_byte_idx_next    = r_byte_idx;
    w_bit_len_next     = r_bit_len;
    w_marker_done_next = r_marker_done;
    w_last_seen_next   = r_last_seen;
    w_block_last_next  = r_block_last;
    case (r_state)
      S_FILL: begin
        if (w_xfer) begin
          w_byte_idx_next = r_byte_idx + 7'd1;
          w_bit_len_next  = r_bit_len + 64'd8;
          if (r_byte_idx == 7'd63) begin
            // Block full: ship raw data, finish padding afterwards if last.
            w_state_next      = S_EMIT;
            w_block_last_next = 1'b0;
            if (in_last) begin
              w_last_seen_next = 1'b1;
            end
          end else if (in_last) begin
            w_state_next     = S_PAD;
            w_last_seen_next = 1'b1;
          end
        end
      end
      S_PAD: begin
        w_marker_done_next = 1'b1;
        w_block_last_next  = w_len_here;
        w_state_next       = S_EMIT;
      end
      S_EMIT: begin
        if (w_hs) begin
          w_byte_idx_next = 7'd0;
          if (r_block_last) begin
            w_state_next       = S_FILL;
            w_bit_len_next     = 64'd0;
            w_marker_done_next = 1'b0;
            w_last_seen_next   = 1'b0;
            w_block_last_next  = 1'b0;
          end else if (r_last_seen) begin
            w_state_next = S_PAD;
          end else begin
            w_state_next = S_FILL;
          end
        end
      end
      default: begin
        w_state_next = S_FILL;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      r_state       <= S_FILL;
      r_block       <= '0;
      r_byte_idx    <= '0;
      r_bit_len     <= '0;
      r_marker_done <= 1'b0;
      r_last_seen   <= 1'b0;
      r_block_last  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_block       <= w_block_next;
      r_byte_idx    <= w_byte_idx_next;
      r_bit_len     <= w_bit_len_next;
      r_marker_done <= w_marker_done_next;
      r_last_seen   <= w_last_seen_next;
      r_block_last  <= w_block_last_next;
    end
  end

endmodule

// File: tb/tb_sha1_pad.sv
// tb_sha1_pad: directed and randomized stimulus for sha1_pad, checked
// against a padding model built from whole-message byte arithmetic.
module tb_sha1_pad;

  logic         wb_clk_i = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         block_valid;
  logic         block_ready = 1'b0;
  logic [511:0] block_o;
  logic         block_last;

  always #5 wb_clk_i = ~wb_clk_i;

  sha1_pad dut (
    .wb_clk_i    (wb_clk_i),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_o     (block_o),
    .block_last  (block_last)
  );

  int errors = 0;
  int checks = 0;

  // stimulus and expectation queues
  logic [7:0]   msg_q[$];
  logic [7:0]   tx_data_q[$];
  bit           tx_last_q[$];
  logic [511:0] exp_blk_q[$];
  bit           exp_last_q[$];
  int           exp_lat_q[$];
  bit           exp_from_hs_q[$];

  int           cyc = 0;
  int           last_xfer_cyc = 0;
  int           last_hs_cyc = 0;
  bit           prev_bv = 0;
  bit           hs_prev = 0;
  bit           ir_after_hs = 0;
  int           policy = 0;
  int           hold_n = 0;
  int           hold_cnt = 0;
  logic [511:0] snap;
  logic         snap_last;
  logic [511:0] last_blk = '0;
  int           blocks_seen = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue msg_q for transmission and derive its padded blocks.
  task automatic add_msg();
    logic [7:0]   pad[$];
    logic [63:0]  bl;
    logic [511:0] blk;
    int           len;
    int           nblk;
    int           data;
    len = msg_q.size();
    bl  = 64'(len) * 64'd8;
    for (int i = 0; i < len; i++) begin
      tx_data_q.push_back(msg_q[i]);
      tx_last_q.push_back(i == len - 1);
    end
    pad = msg_q;
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pad.push_back(bl[8*i +: 8]);
    nblk = pad.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int n = 0; n < 64; n++) begin
        blk[32*(n/4) + 24 - 8*(n%4) +: 8] = pad[64*b + n];
      end
      exp_blk_q.push_back(blk);
      exp_last_q.push_back(b == nblk - 1);
      data = len - 64 * b;
      if (data >= 64) begin
        exp_lat_q.push_back(1);
        exp_from_hs_q.push_back(0);
      end else if (data > 0) begin
        exp_lat_q.push_back(2);
        exp_from_hs_q.push_back(0);
      end else begin
        exp_lat_q.push_back(2);
        exp_from_hs_q.push_back(1);
      end
    end
  endtask

  // One clock cycle: observe outputs at the falling edge, then drive inputs.
  task automatic step();
    bit r;
    int lat;
    @(negedge wb_clk_i);
    cyc++;
    if (hs_prev) begin
      chk("in_ready_after_hs", in_ready, ir_after_hs);
      chk("no_back_to_back", block_valid, 0);
    end
    if (block_valid && !prev_bv) begin
      if (exp_blk_q.size() == 0) begin
        chk("unexpected_block", block_valid, 0);
      end else begin
        lat = exp_from_hs_q[0] ? (cyc - last_hs_cyc) : (cyc - last_xfer_cyc);
        chk("block_latency", lat, exp_lat_q[0]);
      end
      snap      = block_o;
      snap_last = block_last;
      hold_cnt  = 0;
    end else if (block_valid) begin
      chk("block_o_stable", block_o, snap);
      chk("block_last_stable", block_last, snap_last);
    end
    if (block_valid) chk("in_ready_while_pending", in_ready, 0);

    if (!block_valid) r = 1'($urandom % 2);
    else if (policy == 0) r = 1'b1;
    else if (policy == 1) r = (($urandom % 3) != 0);
    else r = (hold_cnt >= hold_n);
    if (block_valid) hold_cnt++;
    block_ready = r;
    hs_prev = block_valid && r;
    if (hs_prev) begin
      if (exp_blk_q.size() > 0) begin
        chk("block_o", block_o, exp_blk_q[0]);
        chk("block_last", block_last, exp_last_q[0]);
        void'(exp_blk_q.pop_front());
        void'(exp_last_q.pop_front());
        void'(exp_lat_q.pop_front());
        void'(exp_from_hs_q.pop_front());
      end
      last_blk = block_o;
      blocks_seen++;
      last_hs_cyc = cyc;
      ir_after_hs = !(exp_from_hs_q.size() > 0 && exp_from_hs_q[0]);
    end

    if (!in_ready) begin
      in_valid = 1'($urandom % 2);
      in_data  = 8'($urandom);
      in_last  = 1'($urandom % 2);
    end else if (tx_data_q.size() > 0 && (policy == 0 || ($urandom % 4) != 0)) begin
      in_valid = 1'b1;
      in_data  = tx_data_q[0];
      in_last  = tx_last_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'b0;
    end
    if (in_valid && in_ready) begin
      void'(tx_data_q.pop_front());
      void'(tx_last_q.pop_front());
      last_xfer_cyc = cyc;
    end
    prev_bv = block_valid;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((tx_data_q.size() > 0 || exp_blk_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drained_within_budget", tx_data_q.size() + exp_blk_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    reset       = 1'b1;
    in_valid    = 1'b0;
    block_ready = 1'b0;
    repeat (n) begin
      @(negedge wb_clk_i);
      cyc++;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_block_valid", block_valid, 0);
      chk("rst_block_last", block_last, 0);
      chk("rst_block_o", block_o, 0);
    end
    reset = 1'b0;
    tx_data_q.delete();
    tx_last_q.delete();
    exp_blk_q.delete();
    exp_last_q.delete();
    exp_lat_q.delete();
    exp_from_hs_q.delete();
    prev_bv = 0;
    hs_prev = 0;
    #1;
    chk("in_ready_after_reset", in_ready, 1);
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
    add_msg();
  endtask

  initial begin
    int lens[13];
    lens = '{1, 55, 56, 63, 64, 65, 119, 120, 128, 0, 0, 0, 0};
    for (int i = 9; i < 13; i++) lens[i] = int'($urandom_range(1, 200));

    do_reset(3);

    // "abc": single final block
    policy = 0;
    load_abc();
    run(500);
    chk("abc_block", last_blk, {32'h00000018, 448'd0, 32'h61626380});

    // 55 zero bytes: marker in last data byte slot, length fits
    msg_q.delete();
    for (int i = 0; i < 55; i++) msg_q.push_back(8'h00);
    add_msg();
    run(500);
    chk("z55_word13_lsb", last_blk[423:416], 8'h80);
    chk("z55_word15", last_blk[511:480], 32'h000001B8);

    // 56 bytes of 0xFF: needs an extra length block
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'hFF);
    add_msg();
    run(500);
    chk("ff56_block2", last_blk, {32'h000001C0, 480'd0});

    // 64 bytes 0x00..0x3F: marker opens the second block
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'(i));
    add_msg();
    run(500);
    chk("seq64_word0", last_blk[31:0], 32'h80000000);
    chk("seq64_word15", last_blk[511:480], 32'h00000200);

    // backpressure: hold the abc block for 10 cycles
    policy = 2;
    hold_n = 10;
    load_abc();
    run(500);
    chk("bp_abc_block", last_blk, {32'h00000018, 448'd0, 32'h61626380});

    // randomized messages with random valid gaps and random block_ready
    policy = 1;
    for (int m = 0; m < 13; m++) begin
      msg_q.delete();
      for (int i = 0; i < lens[m]; i++) msg_q.push_back(8'($urandom));
      add_msg();
      run(5000);
    end

    // abandon a message mid-stream with reset, then send abc
    policy = 0;
    for (int i = 0; i < 20; i++) begin
      tx_data_q.push_back(8'($urandom));
      tx_last_q.push_back(1'b0);
    end
    run(500);
    do_reset(2);
    blocks_seen = 0;
    load_abc();
    run(500);
    chk("abc_after_reset", last_blk, {32'h00000018, 448'd0, 32'h61626380});
    chk("abc_after_reset_count", blocks_seen, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
